// File: rtl/sync_fifo_p.sv
// Single-clock FIFO with full-depth use, occupancy, thresholds and sticky error flags.
// FWFT=1: write-to-dout 1 cycle; FWFT=0: read data 1 cycle after rd; we ignored when full, rd ignored when empty.
module sync_fifo_p #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 6,
  parameter int AFULL_TH  = 56,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [WIDTH-1:0]  din,
  input  logic              rd,
  output logic [WIDTH-1:0]  dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0] ONE_C    = (ADDR_W+1)'(1);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              wr_acc, rd_acc;
  logic [ADDR_W-1:0] rd_idx;

  // The extra wrap bit makes the pointer difference span 0..DEPTH inclusive.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign rd_idx       = rd_ptr_q[ADDR_W-1:0];

  assign dout       = (FWFT != 0) ? mem_q[rd_idx] : dout_q;
  assign dout_valid = (FWFT != 0) ? !empty : dout_vld_q;

  always_comb begin
    wr_acc     = we && !full;
    rd_acc     = rd && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_d      = ovf_q | (we & full);
    udf_d      = udf_q | (rd & empty);
    dout_d     = dout_q;
    dout_vld_d = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
      dout_d   = mem_q[rd_idx];
    end
  end

  // Storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem_q[wr_ptr_q[ADDR_W-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_p.sv
// Bench for sync_fifo_p: three configurations checked against a queue-based model.
module tb_sync_fifo_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        we0 = 1'b0, rd0 = 1'b0, we1 = 1'b0, rd1 = 1'b0, we2 = 1'b0, rd2 = 1'b0;
  logic [7:0]  din0 = '0, din1 = '0;
  logic [15:0] din2 = '0;

  logic [7:0]  dout0, dout1;
  logic [15:0] dout2;
  logic        dv0, dv1, dv2, em0, em1, em2, fu0, fu1, fu2;
  logic        af0, af1, af2, ae0, ae1, ae2, ov0, ov1, ov2, un0, un1, un2;
  logic [6:0]  cnt0, cnt1;
  logic [2:0]  cnt2;

  sync_fifo_p u_dut0 (
    .clk(clk), .reset(reset), .we(we0), .din(din0), .rd(rd0), .dout(dout0),
    .dout_valid(dv0), .empty(em0), .full(fu0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ov0), .underflow(un0)
  );

  sync_fifo_p #(.FWFT(0)) u_dut1 (
    .clk(clk), .reset(reset), .we(we1), .din(din1), .rd(rd1), .dout(dout1),
    .dout_valid(dv1), .empty(em1), .full(fu1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ov1), .underflow(un1)
  );

  sync_fifo_p #(.WIDTH(16), .ADDR_W(2), .AFULL_TH(3), .AEMPTY_TH(1), .FWFT(1)) u_dut2 (
    .clk(clk), .reset(reset), .we(we2), .din(din2), .rd(rd2), .dout(dout2),
    .dout_valid(dv2), .empty(em2), .full(fu2), .almost_full(af2), .almost_empty(ae2),
    .count(cnt2), .overflow(ov2), .underflow(un2)
  );

  int ncmp = 0;
  int nfail = 0;

  // Reference model: contents as a queue, plus the rules for flags and read data.
  logic [15:0] mq [$];
  int          cur, m_depth, m_af, m_ae, m_fwft;
  logic [15:0] m_mask;
  logic        m_ovf, m_udf, m_vexp;
  logic [15:0] m_dexp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sel(input int k);
    cur    = k;
    m_fwft = (k == 1) ? 0 : 1;
    m_depth = (k == 2) ? 4 : 64;
    m_af   = (k == 2) ? 3 : 56;
    m_ae   = (k == 2) ? 1 : 4;
    m_mask = (k == 2) ? 16'hFFFF : 16'h00FF;
  endtask

  task automatic step(input bit w, input bit r, input logic [15:0] d, input bit rst, input string tag);
    logic [31:0] o_cnt, o_dout;
    logic        o_em, o_fu, o_af, o_ae, o_ov, o_un, o_dv;
    int          c;
    reset = rst;
    we0 = (cur == 0) && w;  rd0 = (cur == 0) && r;
    we1 = (cur == 1) && w;  rd1 = (cur == 1) && r;
    we2 = (cur == 2) && w;  rd2 = (cur == 2) && r;
    din0 = d[7:0]; din1 = d[7:0]; din2 = d;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_vexp = 1'b0; m_dexp = '0;
    end else begin
      c = mq.size();
      if (w && c == m_depth) m_ovf = 1'b1;
      if (r && c == 0)       m_udf = 1'b1;
      m_vexp = 1'b0;
      if (r && c != 0) begin
        m_dexp = mq.pop_front();
        m_vexp = 1'b1;
      end
      if (w && c != m_depth) mq.push_back(d & m_mask);
    end
    #1;
    reset = 1'b0;
    we0 = 1'b0; rd0 = 1'b0; we1 = 1'b0; rd1 = 1'b0; we2 = 1'b0; rd2 = 1'b0;
    case (cur)
      0: begin o_cnt = 32'(cnt0); o_dout = 32'(dout0); o_em = em0; o_fu = fu0; o_af = af0;
               o_ae = ae0; o_ov = ov0; o_un = un0; o_dv = dv0; end
      1: begin o_cnt = 32'(cnt1); o_dout = 32'(dout1); o_em = em1; o_fu = fu1; o_af = af1;
               o_ae = ae1; o_ov = ov1; o_un = un1; o_dv = dv1; end
      default: begin o_cnt = 32'(cnt2); o_dout = 32'(dout2); o_em = em2; o_fu = fu2; o_af = af2;
               o_ae = ae2; o_ov = ov2; o_un = un2; o_dv = dv2; end
    endcase
    c = mq.size();
    chk({tag, ".count"},        o_cnt, 32'(c));
    chk({tag, ".empty"},        32'(o_em), 32'(c == 0));
    chk({tag, ".full"},         32'(o_fu), 32'(c == m_depth));
    chk({tag, ".almost_full"},  32'(o_af), 32'(c >= m_af));
    chk({tag, ".almost_empty"}, 32'(o_ae), 32'(c <= m_ae));
    chk({tag, ".overflow"},     32'(o_ov), 32'(m_ovf));
    chk({tag, ".underflow"},    32'(o_un), 32'(m_udf));
    if (m_fwft != 0) begin
      chk({tag, ".dout_valid"}, 32'(o_dv), 32'(c != 0));
      if (c != 0) chk({tag, ".dout"}, o_dout, 32'(mq[0]));
    end else begin
      chk({tag, ".dout_valid"}, 32'(o_dv), 32'(m_vexp));
      chk({tag, ".dout"},       o_dout, 32'(m_dexp));
    end
  endtask

  task automatic rand_run(input int n, input string tag);
    int pw;
    for (int i = 0; i < n; i++) begin
      pw = (((i / 40) % 2) == 0) ? 80 : 25;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (105 - pw),
           16'($urandom), 1'b0, tag);
    end
  endtask

  initial begin
    // Default configuration, first-word-fall-through.
    sel(0);
    step(1'b0, 1'b0, 16'h0, 1'b1, "rst0");
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 16'(i), 1'b0, "fill");
    step(1'b1, 1'b0, 16'h00AA, 1'b0, "wr_full");
    step(1'b1, 1'b1, 16'h00BB, 1'b0, "wr_rd_full");
    for (int i = 0; i < 63; i++) step(1'b0, 1'b1, 16'h0, 1'b0, "drain");
    step(1'b1, 1'b1, 16'h005A, 1'b0, "wr_rd_empty");
    step(1'b0, 1'b1, 16'h0, 1'b0, "pop_5a");
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 16'(i), 1'b0, "preload");
    for (int i = 40; i < 240; i++) step(1'b1, 1'b1, 16'(i), 1'b0, "wrap");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'h0, 1'b0, "to30");
    step(1'b1, 1'b0, 16'h0077, 1'b1, "rst_mid");
    step(1'b0, 1'b0, 16'h0, 1'b0, "post_rst");
    step(1'b1, 1'b0, 16'h0033, 1'b0, "wr_after_rst");
    step(1'b0, 1'b1, 16'h0, 1'b0, "rd_after_rst");
    rand_run(400, "rand0");

    // Registered-read configuration.
    sel(1);
    step(1'b0, 1'b0, 16'h0, 1'b1, "rst1");
    step(1'b1, 1'b0, 16'h0011, 1'b0, "wr11");
    step(1'b1, 1'b0, 16'h0022, 1'b0, "wr22");
    step(1'b0, 1'b1, 16'h0, 1'b0, "rd11");
    step(1'b0, 1'b0, 16'h0, 1'b0, "hold11");
    step(1'b0, 1'b0, 16'h0, 1'b0, "hold11b");
    step(1'b0, 1'b1, 16'h0, 1'b0, "rd22");
    step(1'b0, 1'b1, 16'h0, 1'b0, "rd_empty");
    rand_run(400, "rand1");

    // Small configuration: 4 entries, 16-bit data.
    sel(2);
    step(1'b0, 1'b0, 16'h0, 1'b1, "rst2");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'hA000 + 16'(i), 1'b0, "fill2");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h0, 1'b0, "drain2");
    rand_run(400, "rand2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_p.md
# sync_fifo_p

Parametrised single-clock FIFO; next generation of the team's 64x8 buffer. Width and depth are generics and the full depth is usable: an extra pointer bit replaces the one-slot-lost full test. Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through or registered read mode. Sits between byte/word producers and consumers in the same clock domain.

## Interface
- WIDTH, 8, data width in bits
- ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries, all usable
- AFULL_TH, 56, almost_full asserts when count >= AFULL_TH (legal 1..DEPTH)
- AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH (legal 0..DEPTH-1)
- FWFT, 1, 1 = first-word-fall-through read; 0 = registered read, 1-cycle latency
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  write enable, active-high
- din  in  WIDTH  write data
- rd  in  1  read strobe, active-high
- dout  out  WIDTH  read data
- dout_valid  out  1  dout holds valid data (meaning depends on FWFT)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AFULL_TH
- almost_empty  out  1  count <= AEMPTY_TH
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x WIDTH register array, not reset. wr_ptr, rd_ptr are ADDR_W+1 bits; low ADDR_W bits address memory, MSB is wrap bit.
- Write accepted iff we && !full: mem[wr_ptr] <= din, wr_ptr += 1 (mod 2**(ADDR_W+1)).
- Read accepted iff rd && !empty: rd_ptr += 1.
- full/empty used for acceptance are the values before the edge. Simultaneous we && rd: when full, read accepted, write rejected (overflow sets); when empty, write accepted, read rejected (underflow sets); otherwise both accepted, count unchanged.
- count = wr_ptr - rd_ptr (ADDR_W+1-bit subtraction, wraps correctly); may be a separate register, must always equal pointer difference.
- Flags empty/full/almost_* are combinational from registered pointers/count; no glitch-dependent logic downstream.
- overflow: set on any cycle with we && full; underflow: set on any cycle with rd && empty. Cleared only by reset. Rejected operations change no other state.
- FWFT=1: dout = mem[rd_ptr[ADDR_W-1:0]] combinationally; dout_valid = !empty. rd consumes the word currently on dout.
- FWFT=0: on accepted read, dout <= mem[rd_ptr] and dout_valid <= 1 for exactly the next cycle; otherwise dout_valid <= 0 and dout holds its last value.

## Timing
- Reset (synchronous, sampled on clk edge): wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0 (unless AFULL_TH misconfigured), overflow = underflow = 0, dout_valid = 0; FWFT=0: dout = 0. FWFT=1: dout is don't-care while empty. Reset overrides we/rd in the same cycle; reset mid-operation discards all contents.
- Write at edge N: count/flags update after edge N; FWFT=1 data visible on dout after edge N when FIFO was empty (write-to-dout latency 1 cycle).
- FWFT=0: rd accepted at edge N -> dout/dout_valid valid after edge N for one cycle.
- Back-to-back reads/writes every cycle supported at full throughput, including across pointer wrap.

## Test plan
- Defaults, FWFT=1: write 0x00..0x3F (64 words) -> full=1, count=64, almost_full first high after the 56th write; 65th write (0xAA) rejected, overflow=1; read 64 -> data 0x00..0x3F in order, empty=1 after last.
- Simultaneous at boundaries: full + we=rd=1 -> count 63, overflow=1, head popped; empty + we=rd=1 with din=0x5A -> count 1, underflow=1, dout=0x5A next cycle.
- Wrap-around: 200 cycles of concurrent we/rd with 40 preloaded words, incrementing data -> count stays 40, output sequence contiguous, no flag change.
- FWFT=0: write 0x11,0x22; rd one cycle -> dout=0x11, dout_valid=1 next cycle only, dout holds 0x11 after; second rd -> 0x22.
- Reset mid-operation: 30 words stored, overflow=1, assert reset one cycle with we=1 -> count=0, empty=1, overflow=0, write in reset cycle not stored.
- Parameter sweep WIDTH=16, ADDR_W=2, AFULL_TH=3, AEMPTY_TH=1: full after 4 writes, almost_full at count 3, almost_empty at count <=1.
